// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: byte FIFO in front of a UART transmitter core.
// The CPU pushes bytes with wr_en. The scheduler pops the head byte whenever
// the core is idle. It issues a one-cycle tx_start, waits for the core to
// raise tx_busy, and then waits for tx_busy to fall before the next byte.
// A missing acknowledge is reported through the sticky tx_err flag.
// A write into a full FIFO is reported through the sticky overflow flag.
module uart_tx_scheduler #(
  parameter int DEPTH       = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     clr_err,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     fifo_full,
  output logic                     fifo_empty,
  output logic                     overflow,
  output logic                     tx_err,
  output logic                     sched_busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] DEPTH_C      = CW'(DEPTH);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          state_q;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [TW-1:0]   timer_q;
  logic            tx_start_q;
  logic            tx_err_q;
  logic [7:0]      tx_data_q;
  logic            pop;
  logic            push;
  logic            drop;

  // Push/pop decode and next FIFO bookkeeping. The pointers are AW bits
  // wide, so they wrap modulo DEPTH on their own. A full FIFO still accepts
  // a write in the same cycle that the scheduler pops it.
  always_comb begin
    pop        = (state_q == IDLE) && (count_q != '0) && !tx_busy;
    push       = wr_en && ((count_q != DEPTH_C) || pop);
    drop       = wr_en && !push;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    // A dropped write outranks a coincident clear.
    overflow_d = drop ? 1'b1 : (clr_err ? 1'b0 : overflow_q);
  end

  // Byte storage. No reset: the contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // FIFO pointers, occupancy and the overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Transmit sequencer, with registered tx_start, tx_data and tx_err.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      timer_q    <= '0;
      tx_err_q   <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      // The clear comes first, so a timeout later in this block wins.
      if (clr_err) begin
        tx_err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (pop) begin
            tx_data_q  <= mem_q[rd_ptr_q];
            tx_start_q <= 1'b1;
            state_q    <= START;
          end
        end
        START: begin
          timer_q <= '0;
          state_q <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (timer_q == TIMEOUT_LAST) begin
            // No acknowledge arrived. Drop this byte and go serve the next one.
            tx_err_q <= 1'b1;
            state_q  <= IDLE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign fifo_count = count_q;
  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign overflow   = overflow_q;
  assign tx_err     = tx_err_q;
  assign sched_busy = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: a table of single-transfer vectors,
// directed multi-cycle corner cases, and a randomized run checked against a
// queue-based model of the FIFO.
module tb_uart_tx_scheduler;

  localparam int DEPTH       = 8;
  localparam int ACK_TIMEOUT = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   wr_en;
  logic [7:0]             wr_data;
  logic                   clr_err;
  logic                   tx_busy;
  logic                   tx_start;
  logic [7:0]             tx_data;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   overflow;
  logic                   tx_err;
  logic                   sched_busy;

  uart_tx_scheduler #(.DEPTH(DEPTH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .clr_err    (clr_err),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .overflow   (overflow),
    .tx_err     (tx_err),
    .sched_busy (sched_busy)
  );

  always #5 clk = ~clk;

  int         n_checks;
  int         n_errors;
  bit         core_auto;
  bit         core_ack;
  int         rise_in;
  int         hold;
  logic [7:0] got_q[$];
  logic [7:0] mq[$];
  bit         m_ovf;

  typedef struct packed {
    logic       wr;
    logic [7:0] d;
    logic       busy;
    logic       st;
    logic [7:0] td;
    logic [3:0] cnt;
    logic       sb;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock and return at the following negedge. A simple
  // transmitter-core model reacts to tx_start while core_auto is set.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (tx_start) begin
      $display("tx_start: byte %02h at %0t", tx_data, $time);
      got_q.push_back(tx_data);
    end
    if (core_auto) begin
      if (tx_start && core_ack) begin
        rise_in = $urandom_range(0, 3);
        hold    = $urandom_range(2, 6);
      end
      if (rise_in > 0) begin
        rise_in--;
        tx_busy = 1'b0;
      end else if (hold > 0) begin
        tx_busy = 1'b1;
        hold--;
      end else begin
        tx_busy = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; wr_en = 1'b0; clr_err = 1'b0; tx_busy = 1'b0;
    rise_in = 0; hold = 0; core_auto = 1'b0; core_ack = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int c;
    c = 0;
    while (sched_busy && c < bound) begin
      tick();
      c++;
    end
    chk(name, 32'(sched_busy), 32'(0));
  endtask

  // Model step after one edge: pop the head if a start shows up, then push
  // the write if the queue had room or was popped this cycle.
  task automatic rnd_resolve(input bit w, input logic [7:0] b, input bit cl);
    int sz;
    bit ovf_set;
    sz = mq.size();
    ovf_set = 1'b0;
    if (tx_start) begin
      if (sz == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL rnd_start: tx_start with data %02h, required no start (queue empty)", tx_data);
      end else begin
        chk("rnd_order", 32'(tx_data), 32'(mq.pop_front()));
      end
    end
    if (w) begin
      if (sz < DEPTH || tx_start) mq.push_back(b);
      else ovf_set = 1'b1;
    end
    m_ovf = ovf_set ? 1'b1 : (cl ? 1'b0 : m_ovf);
    chk("rnd_count", 32'(fifo_count), 32'(mq.size()));
    chk("rnd_overflow", 32'(overflow), 32'(m_ovf));
    chk("rnd_full", 32'(fifo_full), 32'(mq.size() == DEPTH));
    chk("rnd_empty", 32'(fifo_empty), 32'(mq.size() == 0));
    chk("rnd_tx_err", 32'(tx_err), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_seq[$];
    int         starts;
    bit         w;
    bit         cl;
    logic [7:0] b;
    int         c;

    n_checks = 0; n_errors = 0; m_ovf = 1'b0;
    core_auto = 1'b0; core_ack = 1'b1; rise_in = 0; hold = 0;
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_err = 1'b0; tx_busy = 1'b0;

    // Reset state
    tick();
    chk("rst_count", 32'(fifo_count), 32'(0));
    chk("rst_empty", 32'(fifo_empty), 32'(1));
    chk("rst_full", 32'(fifo_full), 32'(0));
    chk("rst_start", 32'(tx_start), 32'(0));
    chk("rst_data", 32'(tx_data), 32'(8'h00));
    chk("rst_ovf", 32'(overflow), 32'(0));
    chk("rst_err", 32'(tx_err), 32'(0));
    chk("rst_sbusy", 32'(sched_busy), 32'(0));
    reset = 1'b0;

    // Single byte 0x41, core busy for 10 cycles
    tbl[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 4'd1, 1'b1};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h41, 4'd0, 1'b1};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 4'd0, 1'b1};
    for (int i = 3; i <= 12; i++) tbl[i] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h41, 4'd0, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 4'd0, 1'b0};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h41, 4'd0, 1'b0};
    for (int i = 0; i < 15; i++) begin
      wr_en = tbl[i].wr; wr_data = tbl[i].d; tx_busy = tbl[i].busy;
      tick();
      chk($sformatf("v%0d_start", i), 32'(tx_start), 32'(tbl[i].st));
      chk($sformatf("v%0d_data", i), 32'(tx_data), 32'(tbl[i].td));
      chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(tbl[i].cnt));
      chk($sformatf("v%0d_sbusy", i), 32'(sched_busy), 32'(tbl[i].sb));
      chk($sformatf("v%0d_empty", i), 32'(fifo_empty), 32'(tbl[i].cnt == 0));
      $display("vector %0d: start=%0b data=%02h count=%0d", i, tx_start, tx_data, fifo_count);
    end
    wr_en = 1'b0;

    // Fill to full, overflow on the ninth write, then push and pop in the same cycle
    do_reset();
    tx_busy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      tick();
    end
    chk("burst_full", 32'(fifo_full), 32'(1));
    chk("burst_count", 32'(fifo_count), 32'(8));
    wr_data = 8'h09;
    tick();
    wr_en = 1'b0;
    chk("ovf_set", 32'(overflow), 32'(1));
    chk("ovf_count", 32'(fifo_count), 32'(8));
    chk("ovf_nostart", 32'(tx_start), 32'(0));
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'(0));
    got_q.delete();
    core_auto = 1'b1; core_ack = 1'b1; rise_in = 0; hold = 0;
    tx_busy = 1'b0; wr_en = 1'b1; wr_data = 8'hAA;
    tick();
    wr_en = 1'b0;
    chk("pushpop_count", 32'(fifo_count), 32'(8));
    chk("pushpop_ovf", 32'(overflow), 32'(0));
    chk("pushpop_start", 32'(tx_start), 32'(1));
    chk("pushpop_data", 32'(tx_data), 32'(8'h01));
    c = 0;
    while (got_q.size() < 9 && c < 400) begin
      tick();
      c++;
    end
    wait_idle("drain_idle", 100);
    chk("drain_n", 32'(got_q.size()), 32'(9));
    exp_seq.delete();
    for (int i = 1; i <= 8; i++) exp_seq.push_back(8'(i));
    exp_seq.push_back(8'hAA);
    for (int i = 0; i < 9 && i < got_q.size(); i++)
      chk($sformatf("drain_byte%0d", i), 32'(got_q[i]), 32'(exp_seq[i]));

    // Acknowledge timeout, then clr_err, then clear and set in the same cycle
    do_reset();
    core_auto = 1'b1; core_ack = 1'b0;
    wr_en = 1'b1; wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    tick();
    chk("to_start1", 32'(tx_start), 32'(1));
    chk("to_data1", 32'(tx_data), 32'(8'h55));
    wr_en = 1'b1; wr_data = 8'h66;
    for (int j = 1; j <= 36; j++) begin
      tick();
      if (j == 1) wr_en = 1'b0;
      if (j == 16) chk("to_err_early", 32'(tx_err), 32'(0));
      if (j == 17) begin
        chk("to_err_set", 32'(tx_err), 32'(1));
        chk("to_nostart", 32'(tx_start), 32'(0));
      end
      if (j == 18) begin
        chk("to_start2", 32'(tx_start), 32'(1));
        chk("to_data2", 32'(tx_data), 32'(8'h66));
      end
      if (j == 19) clr_err = 1'b1;
      if (j == 20) begin
        clr_err = 1'b0;
        chk("to_err_clr", 32'(tx_err), 32'(0));
      end
      if (j == 34) begin
        chk("to_err_still0", 32'(tx_err), 32'(0));
        clr_err = 1'b1;
      end
      if (j == 35) begin
        chk("to_set_wins", 32'(tx_err), 32'(1));
        clr_err = 1'b0;
      end
    end
    wait_idle("to_idle", 100);

    // Reset during WAIT_DONE with three bytes queued
    do_reset();
    wr_en = 1'b1; wr_data = 8'h11;
    tick();
    wr_en = 1'b0;
    tick();
    chk("rm_start", 32'(tx_start), 32'(1));
    chk("rm_data", 32'(tx_data), 32'(8'h11));
    tx_busy = 1'b1;
    wr_en = 1'b1; wr_data = 8'h22; tick();
    wr_data = 8'h33; tick();
    wr_data = 8'h44; tick();
    chk("rm_count3", 32'(fifo_count), 32'(3));
    reset = 1'b1; wr_en = 1'b1; wr_data = 8'h99; clr_err = 1'b1;
    tick();
    chk("rm_count0", 32'(fifo_count), 32'(0));
    chk("rm_start0", 32'(tx_start), 32'(0));
    chk("rm_data0", 32'(tx_data), 32'(8'h00));
    chk("rm_sbusy", 32'(sched_busy), 32'(0));
    chk("rm_empty", 32'(fifo_empty), 32'(1));
    chk("rm_full", 32'(fifo_full), 32'(0));
    reset = 1'b0; wr_en = 1'b0; clr_err = 1'b0; tx_busy = 1'b0;
    starts = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_start) starts++;
    end
    chk("rm_no_start", 32'(starts), 32'(0));
    wr_en = 1'b1; wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    tick();
    chk("rm_new_start", 32'(tx_start), 32'(1));
    chk("rm_new_data", 32'(tx_data), 32'(8'h77));

    // Randomized traffic checked against the queue model
    do_reset();
    core_auto = 1'b1; core_ack = 1'b1;
    mq.delete(); m_ovf = 1'b0;
    for (int k = 0; k < 800; k++) begin
      w  = ($urandom_range(0, 99) < 45);
      cl = ($urandom_range(0, 99) < 4);
      b  = 8'($urandom);
      wr_en = w; wr_data = b; clr_err = cl;
      tick();
      rnd_resolve(w, b, cl);
    end
    wr_en = 1'b0; clr_err = 1'b0;
    c = 0;
    while (sched_busy && c < 600) begin
      tick();
      rnd_resolve(1'b0, 8'h00, 1'b0);
      c++;
    end
    chk("rnd_drain_idle", 32'(sched_busy), 32'(0));
    chk("rnd_drain_model", 32'(mq.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of byte entries in the transmit FIFO (power of two, 2..16).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, meaning maximum number of cycles to wait for tx_busy to rise after tx_start.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  CPU write strobe for the UART_TX address (address-decode enable AND MemWrite).
REQ-006 SHALL have port wr_data  input  8  byte to enqueue; sampled when wr_en=1.
REQ-007 SHALL have port clr_err  input  1  clears the overflow and tx_err sticky flags.
REQ-008 SHALL have port tx_busy  input  1  busy indication from the UART transmitter core.
REQ-009 SHALL have port tx_start  output  1  one-cycle start pulse to the UART transmitter core.
REQ-010 SHALL have port tx_data  output  8  byte presented to the UART transmitter core.
REQ-011 SHALL have port fifo_count  output  $clog2(DEPTH)+1  number of bytes queued.
REQ-012 SHALL have port fifo_full  output  1  fifo_count==DEPTH.
REQ-013 SHALL have port fifo_empty  output  1  fifo_count==0.
REQ-014 SHALL have port overflow  output  1  sticky flag: a write was dropped.
REQ-015 SHALL have port tx_err  output  1  sticky flag: the transmitter failed to acknowledge tx_start.
REQ-016 SHALL have port sched_busy  output  1  high whenever state!=IDLE or FIFO not empty (CPU status bit for UART_BUSY reads).

Function
REQ-017 SHALL implement a circular FIFO with read/write pointers wrapping modulo DEPTH.
REQ-018 SHALL accept a push when wr_en=1 and (fifo_count<DEPTH or a pop occurs in the same cycle).
REQ-019 SHALL drop the write and set overflow on the next edge when wr_en=1, FIFO full, and no same-cycle pop; FIFO contents stay unchanged.
REQ-020 SHALL leave fifo_count unchanged on a simultaneous push and pop, and increment/decrement it by one on a push-only/pop-only cycle.
REQ-021 SHALL implement states IDLE, START, WAIT_ACK, WAIT_DONE.
REQ-022 IDLE: if FIFO non-empty and tx_busy=0, SHALL register the head byte into tx_data, pop it, and enter START on the next edge; otherwise remain in IDLE.
REQ-023 START: SHALL drive tx_start=1 for exactly this one cycle, hold tx_data stable, and go to WAIT_ACK.
REQ-024 WAIT_ACK: on tx_busy=1, SHALL go to WAIT_DONE; after ACK_TIMEOUT cycles without tx_busy=1, SHALL set tx_err, discard the byte, and return to IDLE.
REQ-025 WAIT_DONE: SHALL remain until tx_busy=0, then return to IDLE; the next byte therefore starts no earlier than two cycles after tx_busy falls.
REQ-026 tx_data SHALL hold its last value outside START/WAIT_ACK/WAIT_DONE; tx_start SHALL be 0 in every state other than START.
REQ-027 Latency: write into an empty FIFO while IDLE with tx_busy=0 SHALL produce tx_start exactly 2 cycles after the wr_en cycle.
REQ-028 clr_err=1 SHALL clear overflow and tx_err on the next edge; if a set condition coincides, set wins.
REQ-029 Bytes SHALL be transmitted in write order with none duplicated.

Reset
REQ-030 On reset=1 at a clock edge, SHALL go to IDLE and clear pointers, fifo_count, overflow, and tx_err; tx_start=0 and tx_data=8'h00; fifo_empty=1; fifo_full=0.
REQ-031 Reset mid-transfer SHALL abandon queued and in-flight bytes, with no tx_start until new data is written after reset deasserts.
REQ-032 reset SHALL take priority over wr_en and clr_err in the same cycle.

Verification
REQ-033 Write 8'h41 at cycle 0 while idle with tx_busy=0 -> tx_start=1 at cycle 2 only, tx_data=8'h41; tx_busy held 10 cycles -> return to IDLE, fifo_empty=1, sched_busy=0.
REQ-034 Burst-write 8'h01..8'h08 with tx_busy held 1 -> fifo_full=1, count=8; ninth write 8'h09 -> overflow=1, 8'h09 never transmitted; release busy -> 8'h01..8'h08 sent in order.
REQ-035 Full FIFO; push in the same cycle IDLE pops -> push accepted, count stays 8, overflow stays 0.
REQ-036 tx_busy never rises after tx_start -> tx_err=1 after 16 cycles in WAIT_ACK, next byte started; clr_err pulse -> tx_err=0.
REQ-037 Assert reset during WAIT_DONE with 3 bytes queued -> next edge count=0, tx_start=0, tx_data=8'h00, state IDLE; no tx_start afterwards without a new write.
